memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage of the pipelined RV32I core.
- Registers execute-stage results into the E/M pipeline register.
- Performs byte/half/word stores and loads on an internal byte-addressed data memory.
- Presents M-stage results (ALU result, load data, PC+4, control) to the writeback stage and to hazard/forwarding logic.

Parameters:
WIDTH, 32, datapath width in bits (only 32 supported)
ADDR_WIDTH, 12, byte-address bits used to index data memory (2^ADDR_WIDTH bytes)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
EnM  input  1  E/M register load enable; 0 = stall (hold)
FlushM  input  1  inserts bubble into E/M register
RegWriteE  input  1  register-file write request from execute
ResultSrcE  input  2  writeback mux select from execute
MemWriteE  input  1  store request from execute
Funct3E  input  3  load/store size and sign (RV32I funct3)
ALUResultE  input  WIDTH  effective address / ALU result
WriteDataE  input  WIDTH  store data (rs2)
RdE  input  5  destination register
PCPlus4E  input  WIDTH  PC+4 of the instruction
RegWriteM  output  1  registered RegWrite
ResultSrcM  output  2  registered ResultSrc
RdM  output  5  registered Rd
ALUResultM  output  WIDTH  registered ALU result (forwarding source)
PCPlus4M  output  WIDTH  registered PC+4
ReadDataM  output  WIDTH  extended load data
MisalignM  output  1  current M-stage access is misaligned

Behaviour:
E/M register:
- Priority at each rising edge:
  - rst_n=0: all registered fields cleared to 0, including MemWriteM and Funct3M.
  - else FlushM=1: RegWriteM, MemWriteM, ResultSrcM, RdM cleared to 0; data fields may take any value.
  - else EnM=1: capture all E inputs.
  - else hold.
- FlushM overrides EnM.
- Reset values of all outputs: 0. ReadDataM follows the memory rule below.

Memory:
- 2^ADDR_WIDTH bytes, little-endian. Not cleared by reset.
- Address is ALUResultM[ADDR_WIDTH-1:0]. Upper bits are ignored, so the address wraps modulo memory size.

Stores:
- Committed at the rising edge ending the M cycle when MemWriteM=1, MisalignM=0 and rst_n=1.
- Size by Funct3M: 000 SB (byte, WriteData[7:0]), 001 SH (2 bytes, [15:0]), 010 SW (4 bytes); other codes treated as SW.
- Unwritten bytes are untouched.
- A stalled store rewrites the same data each cycle; this is harmless.

Loads:
- Combinational from registered address. ReadDataM is valid in the same cycle the instruction occupies M, so load latency is 1 cycle after E capture.
- Extension by Funct3M: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; other codes treated as LW.
- ReadDataM is computed regardless of ResultSrcM; writeback decides use.

Misalignment:
- MisalignM=1 when size is half and addr[0]=1, or size is word and addr[1:0]!=00.
- While MisalignM=1: ReadDataM=0 and the store is suppressed.
- MisalignM is computed independent of MemWrite; a bubble has Funct3M=0, so MisalignM=0.

Ordering:
- Same-cycle read of a byte being stored returns old data.
- A load in the cycle after a store sees the new data.
- Reset asserted mid-stall drops the held instruction; any pending store in M at that edge is not committed.

Test Plan:
- Reset: rst_n=0 one edge with EnM=1, MemWriteE=1 -> all outputs 0, no memory write; release -> normal capture next edge.
- Word store/load: SW 0xDEADBEEF at 0x010, then LW 0x010 -> ReadDataM=0xDEADBEEF one cycle after the store leaves M; Funct3 010.
- Sub-word: SB 0x80 at 0x013 over 0xDEADBEEF -> LW=0x80ADBEEF, LB 0x013=0xFFFFFF80, LBU=0x00000080, LH 0x012=0xFFFF80AD, LHU=0x000080AD.
- Misaligned: SW at 0x011 -> MisalignM=1, memory unchanged (LW 0x010 still 0x80ADBEEF); LH at 0x013 -> ReadDataM=0, MisalignM=1.
- Stall/flush: EnM=0 for 3 cycles -> M outputs hold exactly; FlushM=1 with EnM=0 -> RegWriteM=0, MemWriteM=0, RdM=0; FlushM with a store in E -> no memory write.
- Wrap: SW 0x12345678 at address 0x00001FF8 (ADDR_WIDTH=12) -> LW at 0xFF8 returns 0x12345678.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: M stage of the pipelined RV32I core.
// Holds the E/M pipeline register, a byte-addressed little-endian data memory,
// sub-word load/store handling and misalignment detection. Loads are
// combinational from the registered address; stores commit at the edge that
// ends the M cycle.
module memory_stage #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EnM,
    input  logic             FlushM,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             MemWriteE,
    input  logic [2:0]       Funct3E,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] PCPlus4E,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             MisalignM
);

    localparam int MEM_BYTES = 1 << ADDR_WIDTH;

    // E/M pipeline register fields
    logic             regWrite_q,  regWrite_d;
    logic [1:0]       resultSrc_q, resultSrc_d;
    logic             memWrite_q,  memWrite_d;
    logic [2:0]       funct3_q,    funct3_d;
    logic [WIDTH-1:0] aluResult_q, aluResult_d;
    logic [WIDTH-1:0] writeData_q, writeData_d;
    logic [4:0]       rd_q,        rd_d;
    logic [WIDTH-1:0] pcPlus4_q,   pcPlus4_d;

    // Data memory, deliberately left uninitialised and unaffected by reset
    logic [7:0] mem [MEM_BYTES];

    // Byte addresses of the four lanes of an access, wrapping modulo memory size
    logic [ADDR_WIDTH-1:0] addr0, addr1, addr2, addr3;

    // Raw bytes read at the four lanes
    logic [7:0] rdByte0, rdByte1, rdByte2, rdByte3;

    // Load-side size decode (funct3[1:0]: 00 byte, 01 half, 1x word)
    logic loadIsHalf, loadIsWord;

    // Store-side size decode (000 byte, 001 half, anything else word)
    logic storeIsByte, storeIsHalf, storeIsWord;
    logic storeMisalign;

    logic [WIDTH-1:0] loadValue;
    logic [3:0]       byteEn;
    logic             storeCommit;

    // Next-state for the E/M register: flush beats enable, otherwise hold
    always_comb begin
        regWrite_d  = regWrite_q;
        resultSrc_d = resultSrc_q;
        memWrite_d  = memWrite_q;
        funct3_d    = funct3_q;
        aluResult_d = aluResult_q;
        writeData_d = writeData_q;
        rd_d        = rd_q;
        pcPlus4_d   = pcPlus4_q;
        if (FlushM) begin
            // A bubble also zeroes funct3 so it can never look misaligned
            regWrite_d  = 1'b0;
            resultSrc_d = 2'b00;
            memWrite_d  = 1'b0;
            funct3_d    = 3'b000;
            aluResult_d = '0;
            writeData_d = '0;
            rd_d        = 5'd0;
            pcPlus4_d   = '0;
        end else if (EnM) begin
            regWrite_d  = RegWriteE;
            resultSrc_d = ResultSrcE;
            memWrite_d  = MemWriteE;
            funct3_d    = Funct3E;
            aluResult_d = ALUResultE;
            writeData_d = WriteDataE;
            rd_d        = RdE;
            pcPlus4_d   = PCPlus4E;
        end
    end

    // E/M register state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regWrite_q  <= 1'b0;
            resultSrc_q <= 2'b00;
            memWrite_q  <= 1'b0;
            funct3_q    <= 3'b000;
            aluResult_q <= '0;
            writeData_q <= '0;
            rd_q        <= 5'd0;
            pcPlus4_q   <= '0;
        end else begin
            regWrite_q  <= regWrite_d;
            resultSrc_q <= resultSrc_d;
            memWrite_q  <= memWrite_d;
            funct3_q    <= funct3_d;
            aluResult_q <= aluResult_d;
            writeData_q <= writeData_d;
            rd_q        <= rd_d;
            pcPlus4_q   <= pcPlus4_d;
        end
    end

    assign RegWriteM  = regWrite_q;
    assign ResultSrcM = resultSrc_q;
    assign RdM        = rd_q;
    assign ALUResultM = aluResult_q;
    assign PCPlus4M   = pcPlus4_q;

    // Lane addresses; upper address bits are simply ignored
    always_comb begin
        addr0 = aluResult_q[ADDR_WIDTH-1:0];
        addr1 = addr0 + ADDR_WIDTH'(1);
        addr2 = addr0 + ADDR_WIDTH'(2);
        addr3 = addr0 + ADDR_WIDTH'(3);
    end

    assign rdByte0 = mem[addr0];
    assign rdByte1 = mem[addr1];
    assign rdByte2 = mem[addr2];
    assign rdByte3 = mem[addr3];

    // Access size decode and misalignment, independent of MemWrite
    always_comb begin
        loadIsHalf  = (funct3_q[1:0] == 2'b01);
        loadIsWord  = funct3_q[1];
        storeIsByte = (funct3_q == 3'b000);
        storeIsHalf = (funct3_q == 3'b001);
        storeIsWord = !storeIsByte && !storeIsHalf;
        MisalignM   = (loadIsHalf && addr0[0]) ||
                      (loadIsWord && (addr0[1:0] != 2'b00));
        // Store codes outside 000/001 act as SW, so 100/101 need their own
        // alignment check to keep a word store from straddling a boundary
        storeMisalign = (storeIsHalf && addr0[0]) ||
                        (storeIsWord && (addr0[1:0] != 2'b00));
    end

    // Load extraction with sign or zero extension
    always_comb begin
        loadValue = {rdByte3, rdByte2, rdByte1, rdByte0};
        case (funct3_q)
            3'b000:  loadValue = {{24{rdByte0[7]}}, rdByte0};
            3'b001:  loadValue = {{16{rdByte1[7]}}, rdByte1, rdByte0};
            3'b100:  loadValue = {24'd0, rdByte0};
            3'b101:  loadValue = {16'd0, rdByte1, rdByte0};
            default: loadValue = {rdByte3, rdByte2, rdByte1, rdByte0};
        endcase
    end

    assign ReadDataM = MisalignM ? '0 : loadValue;

    // Store byte enables and commit qualification
    always_comb begin
        byteEn = 4'b1111;
        if (storeIsByte) begin
            byteEn = 4'b0001;
        end else if (storeIsHalf) begin
            byteEn = 4'b0011;
        end
        storeCommit = memWrite_q && !MisalignM && !storeMisalign && rst_n;
    end

    // Memory write port; untouched lanes keep their previous contents
    always_ff @(posedge clk) begin
        if (storeCommit) begin
            if (byteEn[0]) mem[addr0] <= writeData_q[7:0];
            if (byteEn[1]) mem[addr1] <= writeData_q[15:8];
            if (byteEn[2]) mem[addr2] <= writeData_q[23:16];
            if (byteEn[3]) mem[addr3] <= writeData_q[31:24];
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage.
// Each operation pushes its expected M-stage view into a queue when driven;
// the owning test pops it once the operation occupies M and compares.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        EnM;
    logic        FlushM;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [4:0]  RdE;
    logic [31:0] PCPlus4E;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] PCPlus4M;
    logic [31:0] ReadDataM;
    logic        MisalignM;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic        memWrite;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        chkRead;
        logic [31:0] expRead;
        logic        expMis;
    } OpT;

    typedef struct {
        logic        chkRead;
        logic [31:0] readData;
        logic        mis;
        logic [71:0] ctl;
    } ExpT;

    ExpT expQ[$];

    memory_stage #(.WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .EnM(EnM), .FlushM(FlushM),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
        .MisalignM(MisalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic OpT mkOp(input logic [2:0] f3, input logic memWrite,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic chk,
                                input logic [31:0] expRead, input logic mis);
        OpT op;
        op.regWrite  = !memWrite;
        op.resultSrc = memWrite ? 2'b00 : 2'b01;
        op.memWrite  = memWrite;
        op.f3        = f3;
        op.addr      = addr;
        op.wdata     = wdata;
        op.rd        = rd;
        op.pc4       = 32'h8000_0000 | 32'({rd, 8'h04});
        op.chkRead   = chk;
        op.expRead   = expRead;
        op.expMis    = mis;
        return op;
    endfunction

    // Drive one op into E, record what M must show, then step past the capture edge
    task automatic applyStimulus(input OpT op);
        ExpT e;
        @(negedge clk);
        EnM        = 1'b1;
        FlushM     = 1'b0;
        RegWriteE  = op.regWrite;
        ResultSrcE = op.resultSrc;
        MemWriteE  = op.memWrite;
        Funct3E    = op.f3;
        ALUResultE = op.addr;
        WriteDataE = op.wdata;
        RdE        = op.rd;
        PCPlus4E   = op.pc4;
        e.chkRead  = op.chkRead;
        e.readData = op.expRead;
        e.mis      = op.expMis;
        e.ctl      = {op.regWrite, op.resultSrc, op.rd, op.addr, op.pc4};
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; EnM = 1'b1; FlushM = 1'b0;
        RegWriteE = 1'b1; ResultSrcE = 2'b10; MemWriteE = 1'b1; Funct3E = 3'b010;
        ALUResultE = 32'h20; WriteDataE = 32'hAAAA_AAAA; RdE = 5'd9; PCPlus4E = 32'h104;
        @(posedge clk); #1;
        checks++;
        if ({RegWriteM, ResultSrcM, RdM} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctl got=%h exp=0", {RegWriteM, ResultSrcM, RdM});
        end
        checks++;
        if (ALUResultM !== 32'd0 || PCPlus4M !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got alu=%h pc4=%h exp=0", ALUResultM, PCPlus4M);
        end
        checks++;
        if (MisalignM !== 1'b0) begin
            failures++;
            $display("FAIL reset_mis got=%b exp=0", MisalignM);
        end
        @(negedge clk);
        rst_n = 1'b1; MemWriteE = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M} !==
            {1'b1, 2'b10, 5'd9, 32'h20, 32'h104}) begin
            failures++;
            $display("FAIL reset_release got rd=%0d alu=%h pc4=%h exp rd=9 alu=20 pc4=104",
                     RdM, ALUResultM, PCPlus4M);
        end
    endtask

    task automatic test_word();
        OpT  ops[$];
        ExpT e;
        ops.push_back(mkOp(3'b010, 1'b1, 32'h010, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0, 1'b0));
        ops.push_back(mkOp(3'b010, 1'b0, 32'h010, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF, 1'b0));
        ops.push_back(mkOp(3'b010, 1'b1, 32'h040, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0, 1'b0));
        ops.push_back(mkOp(3'b001, 1'b1, 32'h042, 32'h5555_BEEF, 5'd0, 1'b0, 32'h0, 1'b0));
        ops.push_back(mkOp(3'b010, 1'b0, 32'h040, 32'h0, 5'd4, 1'b1, 32'hBEEF_F00D, 1'b0));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = expQ.pop_front();
            if (e.chkRead) begin
                checks++;
                if (ReadDataM !== e.readData) begin
                    failures++;
                    $display("FAIL word[%0d] read got=%h exp=%h", i, ReadDataM, e.readData);
                end
            end
            checks++;
            if (MisalignM !== e.mis) begin
                failures++;
                $display("FAIL word[%0d] mis got=%b exp=%b", i, MisalignM, e.mis);
            end
            checks++;
            if ({RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M} !== e.ctl) begin
                failures++;
                $display("FAIL word[%0d] ctl got=%h exp=%h", i,
                         {RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M}, e.ctl);
            end
        end
    endtask

    task automatic test_subword();
        OpT  ops[$];
        ExpT e;
        ops.push_back(mkOp(3'b000, 1'b1, 32'h013, 32'h1234_5680, 5'd0, 1'b0, 32'h0, 1'b0));
        ops.push_back(mkOp(3'b010, 1'b0, 32'h010, 32'h0, 5'd5, 1'b1, 32'h80AD_BEEF, 1'b0));
        ops.push_back(mkOp(3'b000, 1'b0, 32'h013, 32'h0, 5'd6, 1'b1, 32'hFFFF_FF80, 1'b0));
        ops.push_back(mkOp(3'b100, 1'b0, 32'h013, 32'h0, 5'd7, 1'b1, 32'h0000_0080, 1'b0));
        ops.push_back(mkOp(3'b001, 1'b0, 32'h012, 32'h0, 5'd8, 1'b1, 32'hFFFF_80AD, 1'b0));
        ops.push_back(mkOp(3'b101, 1'b0, 32'h012, 32'h0, 5'd9, 1'b1, 32'h0000_80AD, 1'b0));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = expQ.pop_front();
            if (e.chkRead) begin
                checks++;
                if (ReadDataM !== e.readData) begin
                    failures++;
                    $display("FAIL subword[%0d] read got=%h exp=%h", i, ReadDataM, e.readData);
                end
            end
            checks++;
            if (MisalignM !== e.mis) begin
                failures++;
                $display("FAIL subword[%0d] mis got=%b exp=%b", i, MisalignM, e.mis);
            end
        end
    endtask

    task automatic test_misalign();
        OpT  ops[$];
        ExpT e;
        ops.push_back(mkOp(3'b010, 1'b1, 32'h011, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0, 1'b1));
        ops.push_back(mkOp(3'b010, 1'b0, 32'h010, 32'h0, 5'd10, 1'b1, 32'h80AD_BEEF, 1'b0));
        ops.push_back(mkOp(3'b001, 1'b0, 32'h013, 32'h0, 5'd11, 1'b1, 32'h0, 1'b1));
        ops.push_back(mkOp(3'b010, 1'b0, 32'h012, 32'h0, 5'd12, 1'b1, 32'h0, 1'b1));
        ops.push_back(mkOp(3'b000, 1'b0, 32'h011, 32'h0, 5'd13, 1'b1, 32'hFFFF_FFBE, 1'b0));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = expQ.pop_front();
            checks++;
            if (ReadDataM !== e.readData) begin
                failures++;
                $display("FAIL misalign[%0d] read got=%h exp=%h", i, ReadDataM, e.readData);
            end
            checks++;
            if (MisalignM !== e.mis) begin
                failures++;
                $display("FAIL misalign[%0d] mis got=%b exp=%b", i, MisalignM, e.mis);
            end
        end
    endtask

    task automatic test_stall_flush();
        ExpT e;
        applyStimulus(mkOp(3'b010, 1'b0, 32'h010, 32'h0, 5'd7, 1'b1, 32'h80AD_BEEF, 1'b0));
        e = expQ.pop_front();
        @(negedge clk);
        EnM = 1'b0; RegWriteE = 1'b0; ResultSrcE = 2'b11; RdE = 5'd20;
        ALUResultE = 32'h44; Funct3E = 3'b001; PCPlus4E = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({RegWriteM, ResultSrcM, RdM, ALUResultM, PCPlus4M} !== e.ctl ||
                ReadDataM !== e.readData) begin
                failures++;
                $display("FAIL stall[%0d] got rd=%0d alu=%h read=%h exp rd=7 alu=10 read=%h",
                         c, RdM, ALUResultM, ReadDataM, e.readData);
            end
        end
        @(negedge clk);
        FlushM = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({RegWriteM, ResultSrcM, RdM, MisalignM} !== 9'd0) begin
            failures++;
            $display("FAIL flush_stalled got=%h exp=0", {RegWriteM, ResultSrcM, RdM, MisalignM});
        end
        @(negedge clk);
        EnM = 1'b1; FlushM = 1'b1; MemWriteE = 1'b1; Funct3E = 3'b010;
        ALUResultE = 32'h010; WriteDataE = 32'h9999_9999; RdE = 5'd0;
        @(posedge clk); #1;
        checks++;
        if ({RegWriteM, RdM} !== 6'd0) begin
            failures++;
            $display("FAIL flush_store got=%h exp=0", {RegWriteM, RdM});
        end
        applyStimulus(mkOp(3'b010, 1'b0, 32'h010, 32'h0, 5'd14, 1'b1, 32'h80AD_BEEF, 1'b0));
        e = expQ.pop_front();
        checks++;
        if (ReadDataM !== e.readData) begin
            failures++;
            $display("FAIL flush_nowrite got=%h exp=%h", ReadDataM, e.readData);
        end
    endtask

    task automatic test_wrap();
        OpT  ops[$];
        ExpT e;
        ops.push_back(mkOp(3'b010, 1'b1, 32'h0000_1FF8, 32'h1234_5678, 5'd0, 1'b0, 32'h0, 1'b0));
        ops.push_back(mkOp(3'b010, 1'b0, 32'h0000_0FF8, 32'h0, 5'd15, 1'b1, 32'h1234_5678, 1'b0));
        ops.push_back(mkOp(3'b010, 1'b0, 32'hABCD_EFF8, 32'h0, 5'd16, 1'b1, 32'h1234_5678, 1'b0));
        ops.push_back(mkOp(3'b101, 1'b0, 32'h0000_0FFA, 32'h0, 5'd17, 1'b1, 32'h0000_1234, 1'b0));
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = expQ.pop_front();
            if (e.chkRead) begin
                checks++;
                if (ReadDataM !== e.readData) begin
                    failures++;
                    $display("FAIL wrap[%0d] read got=%h exp=%h", i, ReadDataM, e.readData);
                end
            end
            checks++;
            if (ALUResultM !== e.ctl[63:32]) begin
                failures++;
                $display("FAIL wrap[%0d] alu got=%h exp=%h", i, ALUResultM, e.ctl[63:32]);
            end
        end
    endtask

    task automatic test_reset_pending_store();
        ExpT e;
        applyStimulus(mkOp(3'b010, 1'b1, 32'h020, 32'h1111_1111, 5'd0, 1'b0, 32'h0, 1'b0));
        e = expQ.pop_front();
        applyStimulus(mkOp(3'b010, 1'b1, 32'h024, 32'h2222_2222, 5'd0, 1'b0, 32'h0, 1'b0));
        e = expQ.pop_front();
        applyStimulus(mkOp(3'b010, 1'b1, 32'h020, 32'h3333_3333, 5'd0, 1'b0, 32'h0, 1'b0));
        e = expQ.pop_front();
        @(negedge clk);
        rst_n = 1'b0; EnM = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({RegWriteM, RdM, ALUResultM} !== 38'd0) begin
            failures++;
            $display("FAIL reset_midstall got alu=%h rd=%0d exp=0", ALUResultM, RdM);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkOp(3'b010, 1'b0, 32'h020, 32'h0, 5'd18, 1'b1, 32'h1111_1111, 1'b0));
        e = expQ.pop_front();
        checks++;
        if (ReadDataM !== e.readData) begin
            failures++;
            $display("FAIL reset_drop_store got=%h exp=%h", ReadDataM, e.readData);
        end
    endtask

    // Watchdog so the run always ends even if the sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    // Main test sequence
    initial begin
        rst_n = 1'b0; EnM = 1'b0; FlushM = 1'b0; RegWriteE = 1'b0; ResultSrcE = 2'b00;
        MemWriteE = 1'b0; Funct3E = 3'b000; ALUResultE = 32'h0; WriteDataE = 32'h0;
        RdE = 5'd0; PCPlus4E = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_stall_flush();
        test_wrap();
        test_reset_pending_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
